// File: rtl/unit_bus.sv
`default_nettype none
// ============================================================================
// Module  : unit_bus
// Purpose : Unit-side responder that moves data between the registers, the ALU,
//           memory and the OTH port on one-hot source/target enables.
// Rev     : 1.0
// ============================================================================
module unit_bus #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           i_unit_ien,
    input  logic [15:0]           i_unit_oen,
    output logic [DATA_WIDTH-1:0] o_ins,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic [DATA_WIDTH-1:0] i_oth_data,
    output logic [DATA_WIDTH-1:0] o_oth_data,
    output logic                  o_oth_valid,
    output logic                  o_alu_carry,
    output logic                  o_err,
    output logic [15:0]           o_xfer_cnt
);

    localparam int c_NULL     = 0;
    localparam int c_IR       = 1;
    localparam int c_PC       = 2;
    localparam int c_AR       = 3;
    localparam int c_DR0      = 4;
    localparam int c_DR1      = 5;
    localparam int c_CR       = 6;
    localparam int c_DR2      = 7;
    localparam int c_ALU_RE   = 8;
    localparam int c_ALU_AD   = 9;
    localparam int c_MEM_NUL2 = 10;
    localparam int c_MEM_NUL3 = 11;
    localparam int c_MEM_PC   = 12;
    localparam int c_MEM_AR   = 13;
    localparam int c_MEM_OTH  = 14;
    localparam int c_MEM_NULL = 15;

    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_ar;
    logic [DATA_WIDTH-1:0] r_dr0;
    logic [DATA_WIDTH-1:0] r_dr1;
    logic [DATA_WIDTH-1:0] r_dr2;
    logic [DATA_WIDTH-1:0] r_cr;
    logic [DATA_WIDTH-1:0] r_alu_re;
    logic                  r_alu_carry;
    logic [DATA_WIDTH-1:0] r_oth_data;
    logic                  r_oth_valid;
    logic                  r_err;
    logic [15:0]           r_xfer_cnt;

    logic                  w_ien_onehot;
    logic                  w_oen_onehot;
    logic                  w_mem_src;
    logic                  w_mem_dst;
    logic                  w_valid;
    logic                  w_discard;
    logic [DATA_WIDTH-1:0] w_bus;
    logic [DATA_WIDTH-1:0] w_addr_full;
    logic [DATA_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH:0]   w_alu_sum;

    assign w_ien_onehot = (i_unit_ien != 16'd0) && ((i_unit_ien & (i_unit_ien - 16'd1)) == 16'd0);
    assign w_oen_onehot = (i_unit_oen != 16'd0) && ((i_unit_oen & (i_unit_oen - 16'd1)) == 16'd0);
    assign w_mem_src    = i_unit_oen[c_MEM_PC] | i_unit_oen[c_MEM_AR];
    assign w_mem_dst    = i_unit_ien[c_MEM_PC] | i_unit_ien[c_MEM_AR];
    // A single address port cannot serve a memory read and a memory write at once.
    assign w_valid      = w_ien_onehot && w_oen_onehot && !(w_mem_src && w_mem_dst);
    assign w_discard    = i_unit_ien[c_NULL] | i_unit_ien[c_MEM_NUL2] |
                          i_unit_ien[c_MEM_NUL3] | i_unit_ien[c_MEM_NULL];

    always_comb begin
        w_bus = '0;
        if (w_valid) begin
            case (1'b1)
                i_unit_oen[c_IR]:      w_bus = r_ir;
                i_unit_oen[c_PC]:      w_bus = r_pc;
                i_unit_oen[c_AR]:      w_bus = r_ar;
                i_unit_oen[c_DR0]:     w_bus = r_dr0;
                i_unit_oen[c_DR1]:     w_bus = r_dr1;
                i_unit_oen[c_CR]:      w_bus = r_cr;
                i_unit_oen[c_DR2]:     w_bus = r_dr2;
                i_unit_oen[c_ALU_RE]:  w_bus = r_alu_re;
                i_unit_oen[c_ALU_AD]:  w_bus = r_dr0;
                i_unit_oen[c_MEM_PC]:  w_bus = i_mem_rdata;
                i_unit_oen[c_MEM_AR]:  w_bus = i_mem_rdata;
                i_unit_oen[c_MEM_OTH]: w_bus = i_oth_data;
                default:               w_bus = '0;
            endcase
        end
    end

    assign w_addr_full = (i_unit_oen[c_MEM_PC] | i_unit_ien[c_MEM_PC]) ? r_pc : r_ar;

    generate
        if (ADDR_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
            assign o_mem_addr = w_addr_full[ADDR_WIDTH-1:0];
        end else begin : g_addr_ext
            assign o_mem_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, w_addr_full};
        end
    endgenerate

    assign w_pc_inc  = r_pc + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign w_alu_sum = {1'b0, r_dr0} + {1'b0, w_bus};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir        <= '0;
            r_pc        <= '0;
            r_ar        <= '0;
            r_dr0       <= '0;
            r_dr1       <= '0;
            r_dr2       <= '0;
            r_cr        <= '0;
            r_alu_re    <= '0;
            r_alu_carry <= 1'b0;
            r_oth_data  <= '0;
            r_oth_valid <= 1'b0;
            r_err       <= 1'b0;
            r_xfer_cnt  <= 16'd0;
        end else begin
            r_oth_valid <= 1'b0;
            if (w_valid) begin
                if (i_unit_ien[c_IR])  r_ir  <= w_bus;
                if (i_unit_ien[c_AR])  r_ar  <= w_bus;
                if (i_unit_ien[c_DR0]) r_dr0 <= w_bus;
                if (i_unit_ien[c_DR1]) r_dr1 <= w_bus;
                if (i_unit_ien[c_DR2]) r_dr2 <= w_bus;
                if (i_unit_ien[c_CR])  r_cr  <= w_bus;
                // An explicit PC load takes priority over the fetch increment.
                if (i_unit_ien[c_PC]) begin
                    r_pc <= w_bus;
                end else if (i_unit_oen[c_MEM_PC]) begin
                    r_pc <= w_pc_inc;
                end
                if (i_unit_ien[c_ALU_AD]) begin
                    {r_alu_carry, r_alu_re} <= w_alu_sum;
                end else if (i_unit_ien[c_ALU_RE]) begin
                    r_alu_re <= w_bus;
                end
                if (i_unit_ien[c_MEM_OTH]) begin
                    r_oth_data  <= w_bus;
                    r_oth_valid <= 1'b1;
                end
                if (!w_discard) begin
                    r_xfer_cnt <= r_xfer_cnt + 16'd1;
                end
            end else begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_ins       = r_ir;
    assign o_mem_wdata = w_bus;
    assign o_mem_we    = w_valid & w_mem_dst;
    assign o_oth_data  = r_oth_data;
    assign o_oth_valid = r_oth_valid;
    assign o_alu_carry = r_alu_carry;
    assign o_err       = r_err;
    assign o_xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_unit_bus.sv
`default_nettype none
// Bench for unit_bus: unit-indexed reference model checked at every falling edge,
// plus literal expectations for the directed scenarios.
module tb_unit_bus;

    localparam int U_NULL = 0, U_IR = 1, U_PC = 2, U_AR = 3, U_DR0 = 4, U_DR1 = 5;
    localparam int U_DR2 = 7, U_ALURE = 8, U_ALUAD = 9, U_MPC = 12, U_MAR = 13, U_OTH = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ien, oen;
    logic [7:0]  rdata, oth_in;
    logic [7:0]  o_ins, o_mem_addr, o_mem_wdata, o_oth_data;
    logic        o_mem_we, o_oth_valid, o_alu_carry, o_err;
    logic [15:0] o_xfer_cnt;

    unit_bus #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_unit_ien(ien), .i_unit_oen(oen),
        .o_ins(o_ins), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_we(o_mem_we), .i_mem_rdata(rdata), .i_oth_data(oth_in),
        .o_oth_data(o_oth_data), .o_oth_valid(o_oth_valid), .o_alu_carry(o_alu_carry),
        .o_err(o_err), .o_xfer_cnt(o_xfer_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    // Model state: m_u[1..7] are IR,PC,AR,DR0,DR1,CR,DR2 and m_u[8] is the ALU result.
    logic [7:0]  m_u [0:15];
    logic        m_carry, m_err, m_oth_valid;
    logic [7:0]  m_oth;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int unit_of(input logic [15:0] m);
        if ($countones(m) != 1) return -1;
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic bit m_valid();
        int s, t;
        s = unit_of(oen);
        t = unit_of(ien);
        if (s < 0 || t < 0) return 1'b0;
        if ((s == U_MPC || s == U_MAR) && (t == U_MPC || t == U_MAR)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_bus();
        int s;
        if (!m_valid()) return 8'h00;
        s = unit_of(oen);
        if (s >= 1 && s <= 8) return m_u[s];
        if (s == U_ALUAD) return m_u[U_DR0];
        if (s == U_MPC || s == U_MAR) return rdata;
        if (s == U_OTH) return oth_in;
        return 8'h00;
    endfunction

    task automatic model_edge();
        logic [7:0] b;
        logic [8:0] sum;
        int s, t;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_u[i] = 8'h00;
            m_carry = 0; m_err = 0; m_oth_valid = 0; m_oth = 0; m_cnt = 0;
        end else if (!m_valid()) begin
            m_err = 1'b1;
            m_oth_valid = 1'b0;
        end else begin
            b = m_bus();
            s = unit_of(oen);
            t = unit_of(ien);
            m_oth_valid = 1'b0;
            if (s == U_MPC && t != U_PC) m_u[U_PC] = m_u[U_PC] + 8'd1;
            if (t >= 1 && t <= 8) m_u[t] = b;
            if (t == U_ALUAD) begin
                sum = {1'b0, m_u[U_DR0]} + {1'b0, b};
                m_u[U_ALURE] = sum[7:0];
                m_carry = sum[8];
            end
            if (t == U_OTH) begin
                m_oth = b;
                m_oth_valid = 1'b1;
            end
            if (!(t == 0 || t == 10 || t == 11 || t == 15)) m_cnt = m_cnt + 16'd1;
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            check("ins", o_ins, m_u[U_IR]);
            check("wdata", o_mem_wdata, m_bus());
            check("addr", o_mem_addr, (oen[U_MPC] | ien[U_MPC]) ? m_u[U_PC] : m_u[U_AR]);
            check("we", o_mem_we, m_valid() && (ien[U_MPC] || ien[U_MAR]));
            check("oth_data", o_oth_data, m_oth);
            check("oth_valid", o_oth_valid, m_oth_valid);
            check("carry", o_alu_carry, m_carry);
            check("err", o_err, m_err);
            check("cnt", o_xfer_cnt, m_cnt);
        end
    end

    function automatic logic [15:0] B(input int u);
        return 16'h0001 << u;
    endfunction

    task automatic set_in(input logic [15:0] ie, input logic [15:0] oe,
                          input logic [7:0] rd, input logic [7:0] ot);
        ien = ie; oen = oe; rdata = rd; oth_in = ot;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [15:0] ie, input logic [15:0] oe,
                         input logic [7:0] rd, input logic [7:0] ot);
        set_in(ie, oe, rd, ot);
        tick();
    endtask

    task automatic load(input int u, input logic [7:0] v);
        drive(B(u), B(U_OTH), 8'h00, v);
    endtask

    task automatic peek(input int u, input logic [7:0] exp, input string name);
        set_in(B(U_NULL), B(u), 8'h00, 8'h00);
        check(name, o_mem_wdata, exp);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_u[i] = 8'h00;
        m_carry = 0; m_err = 0; m_oth_valid = 0; m_oth = 0; m_cnt = 0;
        rst_n = 1'b0;
        set_in(B(U_NULL), B(U_NULL), 8'h00, 8'h00);
        tick();
        run = 1'b1;
        tick();
        rst_n = 1'b1;
        check("rst_ins", o_ins, 8'h00);
        check("rst_cnt", o_xfer_cnt, 16'h0000);
        check("rst_err", o_err, 1'b0);

        // Fetch into IR from MEM[PC]
        set_in(B(U_IR), B(U_MPC), 8'h34, 8'h00);
        check("t1_addr", o_mem_addr, 8'h00);
        tick();
        check("t1_ins", o_ins, 8'h34);
        check("t1_cnt", o_xfer_cnt, 16'h0001);
        peek(U_PC, 8'h01, "t1_pc");

        // ALU add with carry out, result moved to DR2
        load(U_DR0, 8'hF0);
        drive(B(U_ALUAD), B(U_MAR), 8'h20, 8'h00);
        check("t2_carry", o_alu_carry, 1'b1);
        peek(U_ALURE, 8'h10, "t2_alure");
        drive(B(U_DR2), B(U_ALURE), 8'h00, 8'h00);
        peek(U_DR2, 8'h10, "t2_dr2");

        // Memory write through AR
        load(U_AR, 8'h55);
        load(U_DR1, 8'hA5);
        set_in(B(U_MAR), B(U_DR1), 8'h00, 8'h00);
        check("t3_we", o_mem_we, 1'b1);
        check("t3_addr", o_mem_addr, 8'h55);
        check("t3_wdata", o_mem_wdata, 8'hA5);
        tick();
        set_in(B(U_NULL), B(U_NULL), 8'h00, 8'h00);
        check("t3_we_off", o_mem_we, 1'b0);
        tick();

        // PC wrap and load-over-increment
        load(U_PC, 8'hFF);
        drive(B(U_DR0), B(U_MPC), 8'h11, 8'h00);
        peek(U_PC, 8'h00, "t4_wrap");
        drive(B(U_PC), B(U_MPC), 8'h80, 8'h00);
        peek(U_PC, 8'h80, "t4_load");

        // ALU_AD as both source and target: DR0 + DR0
        drive(B(U_ALUAD), B(U_ALUAD), 8'h00, 8'h00);
        peek(U_ALURE, 8'h22, "t4_dbl");
        drive(B(U_DR1), B(U_DR1), 8'h00, 8'h00);
        peek(U_DR1, 8'hA5, "t4_self");

        // Invalid enables: two-hot, zero, and memory read+write conflict
        set_in(16'h0006, B(U_DR0), 8'h00, 8'h00);
        check("t5_we", o_mem_we, 1'b0);
        check("t5_bus", o_mem_wdata, 8'h00);
        tick();
        check("t5_err", o_err, 1'b1);
        peek(U_PC, 8'h80, "t5_pc_kept");
        drive(16'h0000, B(U_DR0), 8'h00, 8'h00);
        drive(B(U_MPC), B(U_MAR), 8'h00, 8'h00);
        drive(B(U_DR2), B(U_DR0), 8'h00, 8'h00);
        check("t5_sticky", o_err, 1'b1);

        // OTH output pulse, then reset mid-sequence
        drive(B(U_OTH), B(U_DR0), 8'h00, 8'h00);
        check("t6_valid", o_oth_valid, 1'b1);
        check("t6_data", o_oth_data, 8'h11);
        drive(B(U_NULL), B(U_NULL), 8'h00, 8'h00);
        check("t6_pulse", o_oth_valid, 1'b0);
        set_in(B(U_OTH), B(U_DR0), 8'h00, 8'h00);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", o_oth_valid, 1'b0);
        check("t6_rst_data", o_oth_data, 8'h00);
        check("t6_rst_err", o_err, 1'b0);
        check("t6_rst_cnt", o_xfer_cnt, 16'h0000);
        check("t6_rst_ins", o_ins, 8'h00);
        rst_n = 1'b1;
        drive(B(U_NULL), B(U_NULL), 8'h00, 8'h00);
        peek(U_DR0, 8'h00, "t6_dr0");

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
